csr_hpm_counters: RTL

CSR_HPM_COUNTERS -- requirements
Module: csr_hpm_counters

---
 rtl/csr_hpm_counters.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/csr_hpm_counters.sv
`default_nettype none
// ============================================================================
//  Module   : csr_hpm_counters
//  Purpose  : Machine-mode performance counter CSR block. It holds mcycle,
//             minstret, mhpmcounter3.. (NUM_HPM of them), their mhpmevent
//             selectors and mcountinhibit. It also provides a combinational
//             CSR read/hit path and a registered CSR write path.
//  Ports    : clk_i, rst_ni        - clock, asynchronous active-low reset
//             csr_valid_i/op_i     - access strobe and csr_op_t operation
//             csr_addr_i/wdata_i   - CSR address, write value or bitmask
//             csr_hit_o            - address lies in this block's map
//             csr_rdata_o          - pre-write read data (0 on a miss)
//             instr_retired_i      - minstret increment strobe
//             event_i              - event strobes, bit e = event number e+1
//             overflow_o           - one-cycle wrap pulse per counter
//  Revision : 1.0 - initial release
// ============================================================================
module csr_hpm_counters #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  csr_valid_i,
    input  logic [2:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [31:0]           csr_wdata_i,
    output logic                  csr_hit_o,
    output logic [31:0]           csr_rdata_o,
    input  logic                  instr_retired_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic [NUM_HPM+1:0]    overflow_o
);

    // Counter slot i: 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k)
    localparam int NUM_CNT = NUM_HPM + 2;
    localparam int SEL_W   = $clog2(NUM_EVENTS + 1);
    localparam int SEL_N   = (NUM_HPM > 0) ? NUM_HPM : 1;

    // csr_op_t encodings that modify state (NONE=0 and READ=1 never do)
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_SET   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [SEL_W-1:0]     sel_q [SEL_N];
    logic [SEL_W-1:0]     sel_d [SEL_N];
    logic [NUM_CNT-1:0]   inh_q, inh_d;   // inhibit bit per counter slot
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [4:0]  w_idx;
    logic [4:0]  w_cnt_idx;
    logic [4:0]  w_evt_idx;
    logic        w_cnt_lo;
    logic        w_cnt_hi;
    logic        w_evt_hit;
    logic        w_inh_hit;

    assign w_idx     = csr_addr_i[4:0];
    // Offset 1 in the counter windows (time/timeh) is not part of this block.
    assign w_cnt_lo  = (csr_addr_i[11:5] == 7'h58) && (w_idx != 5'd1);
    assign w_cnt_hi  = (csr_addr_i[11:5] == 7'h5C) && (w_idx != 5'd1);
    assign w_evt_hit = (csr_addr_i[11:5] == 7'h19) && (w_idx >= 5'd3);
    assign w_inh_hit = (csr_addr_i == 12'h320);

    // Offset 0 -> slot 0, offset 2 -> slot 1, offset 3+k -> slot 2+k
    assign w_cnt_idx = (w_idx == 5'd0) ? 5'd0 : (w_idx - 5'd1);
    assign w_evt_idx = w_idx - 5'd3;

    assign csr_hit_o = w_cnt_lo | w_cnt_hi | w_evt_hit | w_inh_hit;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] w_inh_rd;
    logic [31:0] w_rdata;
    logic [63:0] w_ext;

    // Architectural mcountinhibit view: bit 1 (time) is hardwired to 0.
    always_comb begin
        w_inh_rd    = '0;
        w_inh_rd[0] = inh_q[0];
        w_inh_rd[2] = inh_q[1];
        for (int k = 0; k < NUM_HPM; k++) begin
            w_inh_rd[3+k] = inh_q[2+k];
        end
    end

    // Slots beyond NUM_CNT / NUM_HPM never match and therefore read 0.
    always_comb begin
        w_rdata = '0;
        w_ext   = '0;
        if (w_cnt_lo || w_cnt_hi) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_cnt_idx == 5'(i)) begin
                    w_ext   = 64'(cnt_q[i]);
                    w_rdata = w_cnt_hi ? w_ext[63:32] : w_ext[31:0];
                end
            end
        end else if (w_evt_hit) begin
            for (int k = 0; k < NUM_HPM; k++) begin
                if (w_evt_idx == 5'(k)) begin
                    w_rdata = 32'(sel_q[k]);
                end
            end
        end else if (w_inh_hit) begin
            w_rdata = w_inh_rd;
        end
    end

    assign csr_rdata_o = w_rdata;

    // ------------------------------------------------------------------
    // Write path: the old value for SET/CLEAR is the architectural read
    // value, so unimplemented bits stay zero through read-modify-write.
    // ------------------------------------------------------------------
    logic        w_we;
    logic [31:0] w_wval;

    assign w_we = csr_valid_i && csr_hit_o &&
                  ((csr_op_i == OP_WRITE) ||
                   (((csr_op_i == OP_SET) || (csr_op_i == OP_CLEAR)) &&
                    (csr_wdata_i != 32'd0)));

    always_comb begin
        case (csr_op_i)
            OP_SET:   w_wval = w_rdata | csr_wdata_i;
            OP_CLEAR: w_wval = w_rdata & ~csr_wdata_i;
            default:  w_wval = csr_wdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Increment conditions (use the current inhibit value, so a write to
    // mcountinhibit only takes effect from the following cycle)
    // ------------------------------------------------------------------
    logic [NUM_CNT-1:0] w_inc;

    always_comb begin
        w_inc    = '0;
        w_inc[0] = ~inh_q[0];
        w_inc[1] = instr_retired_i & ~inh_q[1];
        for (int k = 0; k < NUM_HPM; k++) begin
            // Selector 0 and values above NUM_EVENTS match no event.
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if ((sel_q[k] == SEL_W'(e + 1)) && event_i[e] && !inh_q[2+k]) begin
                    w_inc[2+k] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        inh_d = inh_q;
        ovf_d = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int k = 0; k < SEL_N; k++) begin
            sel_d[k] = sel_q[k];
        end

        // A write to either half beats the increment; the other half holds.
        for (int i = 0; i < NUM_CNT; i++) begin
            if (w_we && w_cnt_lo && (w_cnt_idx == 5'(i))) begin
                cnt_d[i][31:0] = w_wval;
            end else if (w_we && w_cnt_hi && (w_cnt_idx == 5'(i))) begin
                cnt_d[i][CNT_WIDTH-1:32] = w_wval[CNT_WIDTH-33:0];
            end else if (w_inc[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
                ovf_d[i] = &cnt_q[i];
            end
        end

        for (int k = 0; k < NUM_HPM; k++) begin
            if (w_we && w_evt_hit && (w_evt_idx == 5'(k))) begin
                sel_d[k] = w_wval[SEL_W-1:0];
            end
        end

        if (w_we && w_inh_hit) begin
            inh_d[0] = w_wval[0];
            inh_d[1] = w_wval[2];
            for (int k = 0; k < NUM_HPM; k++) begin
                inh_d[2+k] = w_wval[3+k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '{default: '0};
            sel_q <= '{default: '0};
            inh_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            inh_q <= inh_d;
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;

endmodule
`default_nettype wire
